// File: rtl/adc_measure_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// adc_measure_arbiter_pkg
// Shared definitions for the ADC measure arbiter and its round-robin picker:
//   - arbiter state encoding
//   - nominal system clock frequency
//   - width helper for requester indices
// ---------------------------------------------------------------------------
package adc_measure_arbiter_pkg;

  // Nominal system clock; TIMEOUT_CLKS defaults to one second of it.
  localparam int unsigned CLK_FREQ = 32'd20000000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_DONE    = 3'd3,
    ST_HOLDOFF = 3'd4
  } arb_state_e;

  // Index width for n requesters, never narrower than one bit.
  function automatic int unsigned calc_id_w(input int unsigned n);
    if (n <= 32'd2) begin
      return 32'd1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/adc_measure_arbiter_rr_select.sv
// ---------------------------------------------------------------------------
// adc_measure_arbiter_rr_select
// Combinational round-robin picker. Scans the pending vector upward starting
// one past the last grant (wrapping modulo NUM_REQ) and returns the first
// pending index.
//   pending_i    : request vector, one bit per requester
//   last_grant_i : index granted most recently
//   grant_o      : selected index (0 when nothing is pending)
//   valid_o      : high when some request is pending
// ---------------------------------------------------------------------------
module adc_measure_arbiter_rr_select
  import adc_measure_arbiter_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 32'd2,
  localparam int unsigned ID_W    = calc_id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] pending_i,
  input  logic [ID_W-1:0]    last_grant_i,
  output logic [ID_W-1:0]    grant_o,
  output logic               valid_o
);

  logic [ID_W-1:0] idx_s;
  logic            hit_s;

  // Walk the ring starting just after the last grant; the first hit sticks.
  always_comb begin
    grant_o = {ID_W{1'b0}};
    valid_o = 1'b0;
    idx_s   = {ID_W{1'b0}};
    hit_s   = 1'b0;
    for (int unsigned off = 32'd1; off <= NUM_REQ; off++) begin
      idx_s   = ID_W'((32'(last_grant_i) + off) % NUM_REQ);
      hit_s   = pending_i[idx_s] && !valid_o;
      grant_o = hit_s ? idx_s : grant_o;
      valid_o = valid_o | hit_s;
    end
  end

endmodule

// File: rtl/adc_measure_arbiter.sv
// ---------------------------------------------------------------------------
// adc_measure_arbiter
// Shares one ADC measure handshake between NUM_REQ requesters with
// round-robin grants, a per-measurement timeout, a holdoff after every
// measurement and sticky error flags.
//   clk, reset_n       : clock and synchronous active-low reset
//   req_start          : per-requester one-cycle start pulses
//   req_done           : per-requester one-cycle completion pulses
//   req_timeout        : qualifies req_done, high when the measurement aborted
//   grant_id           : current / last granted requester (held until next grant)
//   adc_measure_start  : one-cycle start pulse to the ADC
//   adc_measure_done   : ADC completion (level or pulse)
//   adc_abort          : one-cycle pulse on timeout
//   err_clear          : clears all sticky error flags
//   err_overrun        : sticky, start while already pending (per requester)
//   err_timeout        : sticky, any timeout
//   err_spurious       : sticky, ADC done outside a measurement
//   monitor            : [0] measurement in flight, [1] timeout pulse
// ---------------------------------------------------------------------------
module adc_measure_arbiter
  import adc_measure_arbiter_pkg::*;
#(
  parameter  int unsigned NUM_REQ      = 32'd2,
  parameter  int unsigned TIMEOUT_CLKS = 32'd20000000,
  parameter  int unsigned HOLDOFF_CLKS = 32'd20,
  localparam int unsigned ID_W         = calc_id_w(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req_start,
  output logic [NUM_REQ-1:0] req_done,
  output logic               req_timeout,
  output logic [ID_W-1:0]    grant_id,
  output logic               adc_measure_start,
  input  logic               adc_measure_done,
  output logic               adc_abort,
  input  logic               err_clear,
  output logic [NUM_REQ-1:0] err_overrun,
  output logic               err_timeout,
  output logic               err_spurious,
  output logic [1:0]         monitor
);

  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  arb_state_e         state_q;
  logic [31:0]        cnt_q;
  logic [NUM_REQ-1:0] pending_q;
  logic [NUM_REQ-1:0] pending_d;
  logic [ID_W-1:0]    last_grant_q;
  logic [ID_W-1:0]    grant_id_q;
  logic               hold_first_q;
  logic               adc_measure_start_q;
  logic [NUM_REQ-1:0] req_done_q;
  logic               req_timeout_q;
  logic               adc_abort_q;
  logic               mon_wait_q;
  logic               mon_to_q;
  logic [NUM_REQ-1:0] err_overrun_q;
  logic [NUM_REQ-1:0] err_overrun_d;
  logic               err_timeout_q;
  logic               err_timeout_d;
  logic               err_spurious_q;
  logic               err_spurious_d;

  logic [ID_W-1:0]    sel_grant_s;
  logic               sel_valid_s;
  logic               take_s;
  logic [NUM_REQ-1:0] grant_mask_s;
  logic [NUM_REQ-1:0] done_mask_s;
  logic               spurious_s;
  logic               timeout_s;

  adc_measure_arbiter_rr_select #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_select (
    .pending_i    (pending_q),
    .last_grant_i (last_grant_q),
    .grant_o      (sel_grant_s),
    .valid_o      (sel_valid_s)
  );

  // Grant qualification, error events and next values of pending / sticky flags.
  always_comb begin
    take_s       = (state_q == ST_IDLE) && sel_valid_s;
    grant_mask_s = ONE_HOT0 << sel_grant_s;
    done_mask_s  = ONE_HOT0 << grant_id_q;
    // A done level still held in the first holdoff cycle belongs to the
    // measurement that just finished.
    spurious_s   = adc_measure_done && (state_q != ST_WAIT) &&
                   !((state_q == ST_HOLDOFF) && hold_first_q);
    timeout_s    = (state_q == ST_WAIT) && !adc_measure_done && (cnt_q == 32'd0);
    pending_d    = (pending_q & ~(take_s ? grant_mask_s : {NUM_REQ{1'b0}})) | req_start;
    // Clear first, then OR in new events so a same-cycle event survives.
    err_overrun_d  = (err_clear ? {NUM_REQ{1'b0}} : err_overrun_q) | (req_start & pending_q);
    err_timeout_d  = (err_clear ? 1'b0 : err_timeout_q) | timeout_s;
    err_spurious_d = (err_clear ? 1'b0 : err_spurious_q) | spurious_s;
  end

  // Arbiter FSM with registered handshake, status and error outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q             <= ST_IDLE;
      cnt_q               <= 32'd0;
      pending_q           <= {NUM_REQ{1'b0}};
      last_grant_q        <= ID_W'(NUM_REQ - 32'd1);
      grant_id_q          <= {ID_W{1'b0}};
      hold_first_q        <= 1'b0;
      adc_measure_start_q <= 1'b0;
      req_done_q          <= {NUM_REQ{1'b0}};
      req_timeout_q       <= 1'b0;
      adc_abort_q         <= 1'b0;
      mon_wait_q          <= 1'b0;
      mon_to_q            <= 1'b0;
      err_overrun_q       <= {NUM_REQ{1'b0}};
      err_timeout_q       <= 1'b0;
      err_spurious_q      <= 1'b0;
    end else begin
      pending_q           <= pending_d;
      err_overrun_q       <= err_overrun_d;
      err_timeout_q       <= err_timeout_d;
      err_spurious_q      <= err_spurious_d;
      // Pulse outputs default low and are raised only by the transitions below.
      adc_measure_start_q <= 1'b0;
      req_done_q          <= {NUM_REQ{1'b0}};
      req_timeout_q       <= 1'b0;
      adc_abort_q         <= 1'b0;
      mon_to_q            <= 1'b0;
      hold_first_q        <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (take_s) begin
            grant_id_q   <= sel_grant_s;
            last_grant_q <= sel_grant_s;
            state_q      <= ST_START;
          end else begin
            state_q      <= ST_IDLE;
          end
        end
        ST_START: begin
          adc_measure_start_q <= 1'b1;
          cnt_q               <= TIMEOUT_CLKS - 32'd1;
          mon_wait_q          <= 1'b1;
          state_q             <= ST_WAIT;
        end
        ST_WAIT: begin
          // Completion is checked first so done wins over an expiring counter.
          if (adc_measure_done) begin
            req_done_q <= done_mask_s;
            mon_wait_q <= 1'b0;
            state_q    <= ST_DONE;
          end else if (timeout_s) begin
            req_done_q    <= done_mask_s;
            req_timeout_q <= 1'b1;
            adc_abort_q   <= 1'b1;
            mon_to_q      <= 1'b1;
            mon_wait_q    <= 1'b0;
            state_q       <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - 32'd1;
          end
        end
        ST_DONE: begin
          if (HOLDOFF_CLKS == 32'd0) begin
            state_q <= ST_IDLE;
          end else begin
            cnt_q        <= HOLDOFF_CLKS - 32'd1;
            hold_first_q <= 1'b1;
            state_q      <= ST_HOLDOFF;
          end
        end
        ST_HOLDOFF: begin
          if (cnt_q == 32'd0) begin
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - 32'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_done          = req_done_q;
  assign req_timeout       = req_timeout_q;
  assign grant_id          = grant_id_q;
  assign adc_measure_start = adc_measure_start_q;
  assign adc_abort         = adc_abort_q;
  assign err_overrun       = err_overrun_q;
  assign err_timeout       = err_timeout_q;
  assign err_spurious      = err_spurious_q;
  assign monitor           = {mon_to_q, mon_wait_q};

endmodule

// File: tb/tb_adc_measure_arbiter.sv
// ---------------------------------------------------------------------------
// tb_adc_measure_arbiter
// Two arbiter instances share one clock:
//   A: 2 requesters, 120-clock timeout, 20-clock holdoff
//   B: 3 requesters, 50-clock timeout, no holdoff
// Each scenario task drives stimulus and compares outputs against values
// derived from the arbitration rules; the random scenario keeps its own
// pending set, round-robin pointer and sticky-flag model.
// ---------------------------------------------------------------------------
module tb_adc_measure_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       a_rst_n, a_req_timeout, a_start, a_adc_done, a_abort, a_err_clear;
  logic       a_err_timeout, a_err_spurious;
  logic [1:0] a_req_start, a_req_done, a_err_overrun, a_monitor;
  logic [0:0] a_grant_id;

  logic       b_rst_n, b_req_timeout, b_start, b_adc_done, b_abort, b_err_clear;
  logic       b_err_timeout, b_err_spurious;
  logic [2:0] b_req_start, b_req_done, b_err_overrun;
  logic [1:0] b_monitor, b_grant_id;

  adc_measure_arbiter #(.NUM_REQ(2), .TIMEOUT_CLKS(120), .HOLDOFF_CLKS(20)) u_dut_a (
    .clk(clk), .reset_n(a_rst_n), .req_start(a_req_start), .req_done(a_req_done),
    .req_timeout(a_req_timeout), .grant_id(a_grant_id), .adc_measure_start(a_start),
    .adc_measure_done(a_adc_done), .adc_abort(a_abort), .err_clear(a_err_clear),
    .err_overrun(a_err_overrun), .err_timeout(a_err_timeout),
    .err_spurious(a_err_spurious), .monitor(a_monitor)
  );

  adc_measure_arbiter #(.NUM_REQ(3), .TIMEOUT_CLKS(50), .HOLDOFF_CLKS(0)) u_dut_b (
    .clk(clk), .reset_n(b_rst_n), .req_start(b_req_start), .req_done(b_req_done),
    .req_timeout(b_req_timeout), .grant_id(b_grant_id), .adc_measure_start(b_start),
    .adc_measure_done(b_adc_done), .adc_abort(b_abort), .err_clear(b_err_clear),
    .err_overrun(b_err_overrun), .err_timeout(b_err_timeout),
    .err_spurious(b_err_spurious), .monitor(b_monitor)
  );

  // Each tick lands 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_a();
    a_rst_n = 1'b0; a_req_start = 2'b00; a_adc_done = 1'b0; a_err_clear = 1'b0;
    tick(); tick();
    a_rst_n = 1'b1;
  endtask

  task automatic reset_b();
    b_rst_n = 1'b0; b_req_start = 3'b000; b_adc_done = 1'b0; b_err_clear = 1'b0;
    tick(); tick();
    b_rst_n = 1'b1;
  endtask

  task automatic wait_a_start(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 60; n++) begin
      tick();
      if (a_start === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_b_start(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 60; n++) begin
      tick();
      if (b_start === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  // Round-robin rule: first pending index scanning upward from last+1, modulo n.
  function automatic int rr_pick(input bit [7:0] pend, input int last, input int n);
    rr_pick = -1;
    for (int off = 1; off <= n; off++) begin
      if (rr_pick < 0 && pend[(last + off) % n]) rr_pick = (last + off) % n;
    end
  endfunction

  task automatic test_reset();
    a_rst_n = 1'b0; b_rst_n = 1'b0;
    a_req_start = 2'b00; a_adc_done = 1'b0; a_err_clear = 1'b0;
    b_req_start = 3'b000; b_adc_done = 1'b0; b_err_clear = 1'b0;
    tick(); tick();
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    checks++;
    if ({a_req_done, a_req_timeout, a_grant_id, a_start, a_abort, a_err_overrun,
         a_err_timeout, a_err_spurious, a_monitor} !== 12'd0) begin
      errors++; $display("FAIL reset_a: outputs %b want all zero", {a_req_done, a_req_timeout,
        a_grant_id, a_start, a_abort, a_err_overrun, a_err_timeout, a_err_spurious, a_monitor});
    end
    checks++;
    if ({b_req_done, b_req_timeout, b_grant_id, b_start, b_abort, b_err_overrun,
         b_err_timeout, b_err_spurious, b_monitor} !== 15'd0) begin
      errors++; $display("FAIL reset_b: outputs %b want all zero", {b_req_done, b_req_timeout,
        b_grant_id, b_start, b_abort, b_err_overrun, b_err_timeout, b_err_spurious, b_monitor});
    end
  endtask

  task automatic test_single();
    int seen;
    reset_a();
    a_req_start = 2'b01; tick(); a_req_start = 2'b00;
    tick();
    checks++;
    if (a_start !== 1'b0) begin errors++; $display("FAIL single_early_start: got %b want 0", a_start); end
    tick();
    checks++;
    if ({a_start, a_grant_id, a_monitor} !== 4'b1_0_01) begin
      errors++; $display("FAIL single_start: start/grant/mon %b want 1001", {a_start, a_grant_id, a_monitor});
    end
    repeat (99) tick();
    a_adc_done = 1'b1; tick(); a_adc_done = 1'b0;
    checks++;
    if ({a_req_done, a_req_timeout, a_grant_id, a_monitor, a_abort} !== 7'b01_0_0_00_0) begin
      errors++; $display("FAIL single_done: done/to/grant/mon/abort %b want 0100000",
        {a_req_done, a_req_timeout, a_grant_id, a_monitor, a_abort});
    end
    // Queue requester 1 now; its start must wait for the 20-clock holdoff.
    a_req_start = 2'b10; tick(); a_req_start = 2'b00;
    checks++;
    if ({a_req_done, a_grant_id} !== 3'b00_0) begin
      errors++; $display("FAIL single_after_done: done/grant %b want 000", {a_req_done, a_grant_id});
    end
    seen = 0;
    for (int n = 2; n <= 30; n++) begin
      tick();
      if (a_start === 1'b1 && seen == 0) seen = n;
    end
    checks++;
    if (seen != 23 || a_grant_id !== 1'b1) begin
      errors++; $display("FAIL single_holdoff: start %0d clocks after done grant %b, want 23 grant 1", seen, a_grant_id);
    end
    a_adc_done = 1'b1; tick(); a_adc_done = 1'b0;
    checks++;
    if ({a_req_done, a_err_spurious} !== 3'b10_0) begin
      errors++; $display("FAIL single_second_done: done/spur %b want 100", {a_req_done, a_err_spurious});
    end
  endtask

  task automatic test_round_robin();
    bit [7:0] pend;
    int last, exp;
    bit ok;
    reset_a();
    pend = 8'h03; last = 1;
    a_req_start = 2'b11; tick(); a_req_start = 2'b00;
    for (int m = 0; m < 6; m++) begin
      wait_a_start(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rr_no_start: measurement %0d never started", m); break; end
      exp = rr_pick(pend, last, 2);
      pend[exp] = 1'b0; last = exp;
      checks++;
      if (a_grant_id !== exp[0:0]) begin
        errors++; $display("FAIL rr_grant: measurement %0d grant %0d want %0d", m, a_grant_id, exp);
      end
      // The served requester immediately asks again.
      a_req_start = 2'b01 << exp; pend[exp] = 1'b1; tick(); a_req_start = 2'b00;
      repeat (5) tick();
      a_adc_done = 1'b1; tick(); a_adc_done = 1'b0;
    end
    checks++;
    if (a_err_overrun !== 2'b00) begin errors++; $display("FAIL rr_overrun: got %b want 00", a_err_overrun); end
  endtask

  task automatic test_overrun_spurious();
    bit ok;
    reset_a();
    a_adc_done = 1'b1; tick(); a_adc_done = 1'b0;
    checks++;
    if ({a_err_spurious, a_err_overrun} !== 3'b1_00) begin
      errors++; $display("FAIL spurious_idle: spur/ovr %b want 100", {a_err_spurious, a_err_overrun});
    end
    a_err_clear = 1'b1; tick(); a_err_clear = 1'b0;
    checks++;
    if (a_err_spurious !== 1'b0) begin errors++; $display("FAIL spurious_clear: got %b want 0", a_err_spurious); end
    a_req_start = 2'b01; tick(); a_req_start = 2'b00;
    wait_a_start(ok);
    a_req_start = 2'b10; tick(); a_req_start = 2'b00; tick();
    checks++;
    if (!ok || a_err_overrun !== 2'b00) begin
      errors++; $display("FAIL overrun_first: started %0d ovr %b want 1 00", ok, a_err_overrun);
    end
    a_req_start = 2'b10; tick(); a_req_start = 2'b00;
    checks++;
    if (a_err_overrun !== 2'b10) begin errors++; $display("FAIL overrun_second: got %b want 10", a_err_overrun); end
    // Clear and a fresh overrun in the same cycle: the event is kept.
    a_err_clear = 1'b1; a_req_start = 2'b10; tick(); a_err_clear = 1'b0; a_req_start = 2'b00;
    checks++;
    if (a_err_overrun !== 2'b10) begin errors++; $display("FAIL overrun_clear_race: got %b want 10", a_err_overrun); end
    a_err_clear = 1'b1; tick(); a_err_clear = 1'b0;
    checks++;
    if ({a_err_overrun, a_err_timeout, a_err_spurious} !== 4'b0000) begin
      errors++; $display("FAIL err_clear_all: ovr/to/spur %b want 0000", {a_err_overrun, a_err_timeout, a_err_spurious});
    end
    a_adc_done = 1'b1; tick(); a_adc_done = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    bit any_start;
    reset_a();
    a_req_start = 2'b10; tick(); a_req_start = 2'b00;
    wait_a_start(ok);
    checks++;
    if (!ok || a_grant_id !== 1'b1) begin
      errors++; $display("FAIL midwait_grant: started %0d grant %b want 1 1", ok, a_grant_id);
    end
    a_req_start = 2'b01; tick(); a_req_start = 2'b00;
    repeat (3) tick();
    a_rst_n = 1'b0; tick(); a_rst_n = 1'b1;
    checks++;
    if ({a_req_done, a_req_timeout, a_grant_id, a_start, a_abort, a_err_overrun,
         a_err_timeout, a_err_spurious, a_monitor} !== 12'd0) begin
      errors++; $display("FAIL midwait_reset: outputs %b want all zero", {a_req_done, a_req_timeout,
        a_grant_id, a_start, a_abort, a_err_overrun, a_err_timeout, a_err_spurious, a_monitor});
    end
    any_start = 1'b0;
    repeat (10) begin tick(); any_start = any_start | (a_start === 1'b1); end
    checks++;
    if (any_start) begin errors++; $display("FAIL midwait_pending: start seen 1 want 0"); end
    a_adc_done = 1'b1; tick(); a_adc_done = 1'b0;
    checks++;
    if ({a_err_spurious, a_err_timeout, a_err_overrun, a_req_done, a_req_timeout} !== 7'b1_0_00_00_0) begin
      errors++; $display("FAIL midwait_late_done: spur/to/ovr/done/rto %b want 1000000",
        {a_err_spurious, a_err_timeout, a_err_overrun, a_req_done, a_req_timeout});
    end
  endtask

  task automatic test_timeout();
    bit ok;
    reset_b();
    b_req_start = 3'b001; tick(); b_req_start = 3'b000;
    wait_b_start(ok);
    repeat (49) tick();
    checks++;
    if (!ok || b_abort !== 1'b0 || b_monitor !== 2'b01) begin
      errors++; $display("FAIL timeout_early: started %0d abort %b mon %b want 1 0 01", ok, b_abort, b_monitor);
    end
    tick();
    checks++;
    if ({b_abort, b_monitor, b_req_done, b_req_timeout, b_err_timeout} !== 8'b1_10_001_1_1) begin
      errors++; $display("FAIL timeout_fire: abort/mon/done/rto/err %b want 11000111",
        {b_abort, b_monitor, b_req_done, b_req_timeout, b_err_timeout});
    end
    tick();
    checks++;
    if ({b_abort, b_monitor, b_req_done, b_err_timeout} !== 7'b0_00_000_1) begin
      errors++; $display("FAIL timeout_after: abort/mon/done/err %b want 0000001",
        {b_abort, b_monitor, b_req_done, b_err_timeout});
    end
    b_err_clear = 1'b1; tick(); b_err_clear = 1'b0;
    checks++;
    if (b_err_timeout !== 1'b0) begin errors++; $display("FAIL timeout_clear: got %b want 0", b_err_timeout); end
    // Done arrives exactly on the clock the counter reaches zero.
    b_req_start = 3'b010; tick(); b_req_start = 3'b000;
    wait_b_start(ok);
    repeat (49) tick();
    b_adc_done = 1'b1; tick(); b_adc_done = 1'b0;
    checks++;
    if (!ok || {b_req_done, b_req_timeout, b_abort, b_err_timeout} !== 6'b010_0_0_0) begin
      errors++; $display("FAIL timeout_tie: started %0d done/rto/abort/err %b want 1 010000",
        ok, {b_req_done, b_req_timeout, b_abort, b_err_timeout});
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int seen;
    logic [1:0] grant_after_done;
    reset_b();
    b_req_start = 3'b011; tick(); b_req_start = 3'b000;
    wait_b_start(ok);
    checks++;
    if (!ok || b_grant_id !== 2'd0) begin
      errors++; $display("FAIL b2b_first: started %0d grant %0d want 1 0", ok, b_grant_id);
    end
    repeat (3) tick();
    b_adc_done = 1'b1; tick(); b_adc_done = 1'b0;
    checks++;
    if (b_req_done !== 3'b001) begin errors++; $display("FAIL b2b_done: got %b want 001", b_req_done); end
    seen = 0; grant_after_done = 2'd3;
    for (int n = 1; n <= 10; n++) begin
      tick();
      if (n == 1) grant_after_done = b_grant_id;
      if (b_start === 1'b1 && seen == 0) seen = n;
    end
    checks++;
    if (seen != 3 || b_grant_id !== 2'd1 || grant_after_done !== 2'd0) begin
      errors++; $display("FAIL b2b_gap: start after %0d grant %0d held %0d want 3 1 0",
        seen, b_grant_id, grant_after_done);
    end
    b_adc_done = 1'b1; tick(); b_adc_done = 1'b0;
    tick();
  endtask

  task automatic test_random();
    bit [7:0] pend;
    bit [2:0] ovr, r;
    int last, exp, k, d, n;
    bit ok, to, any_to;
    reset_b();
    pend = 8'h00; ovr = 3'b000; last = 2; any_to = 1'b0;
    for (int it = 0; it < 40; it++) begin
      if (pend == 8'h00) begin
        r = 3'($urandom_range(1, 7));
        b_req_start = r; pend[2:0] = r; tick(); b_req_start = 3'b000;
      end
      wait_b_start(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rand_no_start: iteration %0d pending %b", it, pend[2:0]); break; end
      exp = rr_pick(pend, last, 3);
      pend[exp] = 1'b0; last = exp;
      checks++;
      if (b_grant_id !== exp[1:0]) begin
        errors++; $display("FAIL rand_grant: iteration %0d grant %0d want %0d", it, b_grant_id, exp);
      end
      k = $urandom_range(1, 5);
      for (int j = 0; j < k; j++) begin
        r = 3'($urandom_range(0, 7));
        ovr = ovr | (r & pend[2:0]);
        pend[2:0] = pend[2:0] | r;
        b_req_start = r; tick();
      end
      b_req_start = 3'b000;
      to = ($urandom_range(0, 4) == 0);
      if (!to) begin
        d = $urandom_range(1, 30);
        repeat (d - 1) tick();
        b_adc_done = 1'b1; tick(); b_adc_done = 1'b0;
      end
      n = 0;
      while (b_req_done === 3'b000 && n < 60) begin tick(); n++; end
      any_to = any_to | to;
      checks++;
      if (b_req_done !== (3'b001 << exp) || b_req_timeout !== to || b_err_timeout !== any_to) begin
        errors++; $display("FAIL rand_done: iteration %0d done %b rto %b err_to %b want %b %b %b",
          it, b_req_done, b_req_timeout, b_err_timeout, 3'b001 << exp, to, any_to);
      end
      checks++;
      if (b_err_overrun !== ovr) begin
        errors++; $display("FAIL rand_overrun: iteration %0d got %b want %b", it, b_err_overrun, ovr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_overrun_spurious();
    test_reset_mid_wait();
    test_timeout();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/adc_measure_arbiter.md
Name: adc_measure_arbiter

Overview:
- Shares the single ADC measure handshake (adc_measure_start / adc_measure_done) between NUM_REQ requesters, e.g. the AZ modulator and a calibration/self-test sequencer.
- Each requester issues single-cycle start pulses and receives a single-cycle done pulse.
- Grants are round-robin, with a per-measurement timeout, an inter-measurement holdoff, and sticky error flags.
- Sits between the modulation blocks and the ADC in the top level.

Parameters:
- NUM_REQ, 2, number of requesters (legal 2..8).
- TIMEOUT_CLKS, 20000000, clocks allowed from adc_measure_start to adc_measure_done (1 s at 20 MHz); legal range ≥ 2.
- HOLDOFF_CLKS, 20, idle clocks forced after each completed or aborted measurement; 0 means no holdoff.

Ports:
- clk  in  1  system clock, 20 MHz.
- reset_n  in  1  synchronous active-low reset.
- req_start  in  NUM_REQ  per-requester start pulse, one cycle.
- req_done  out  NUM_REQ  per-requester completion pulse, one cycle.
- req_timeout  out  1  qualifies req_done: high in the same cycle when the measurement aborted.
- grant_id  out  ID_W  index of current/last granted requester; ID_W = clog2(NUM_REQ), minimum 1.
- adc_measure_start  out  1  one-cycle start pulse to the ADC.
- adc_measure_done  in  1  ADC completion, level or pulse.
- adc_abort  out  1  one-cycle pulse on timeout, to reset the ADC sequencer.
- err_clear  in  1  clears all sticky error flags.
- err_overrun  out  NUM_REQ  sticky: req_start arrived while that requester was already pending.
- err_timeout  out  1  sticky: any timeout occurred.
- err_spurious  out  1  sticky: adc_measure_done high outside WAIT.
- monitor  out  2  [0] high in WAIT; [1] one-cycle pulse on timeout.

Behaviour:
- Reset: synchronous, sampled on the rising clk edge with reset_n=0; it overrides everything, including mid-measurement. Reset values:
  - All outputs, pending bits and error flags = 0.
  - grant_id = 0; last-grant pointer = NUM_REQ-1, so requester 0 has first priority.
  - State = IDLE.
- Pending: req_start[i]=1 sets pending[i] at the next edge. If pending[i] is already 1, set err_overrun[i]; the request is not queued twice.
- States: IDLE, START, WAIT, DONE, HOLDOFF.
- IDLE, if any pending bit is set:
  - Select the first pending index scanning upward from last_grant+1, modulo NUM_REQ.
  - Load grant_id, clear that pending bit, update last_grant, go to START.
- START:
  - adc_measure_start=1 for exactly this cycle.
  - Load timeout counter with TIMEOUT_CLKS-1; go to WAIT.
- Latency: req_start sampled at edge k with the arbiter idle → adc_measure_start high in the cycle after edge k+2.
- WAIT:
  - Counter decrements each clock.
  - adc_measure_done=1 → DONE.
  - Else counter==0 → DONE with timeout flag set, adc_abort=1 and monitor[1]=1 for one cycle, err_timeout set.
  - adc_measure_done and counter==0 in the same cycle: done wins, no timeout.
- DONE:
  - req_done[grant_id]=1 for one cycle; req_timeout mirrors the timeout flag in the same cycle.
  - Load holdoff counter; go to HOLDOFF, or to IDLE if HOLDOFF_CLKS=0.
- HOLDOFF: count HOLDOFF_CLKS clocks, then IDLE. New requests keep accumulating as pending.
- Spurious done: adc_measure_done=1 in IDLE, START, DONE or HOLDOFF sets err_spurious and is otherwise ignored.
  - Exception: in the first cycle of HOLDOFF only, a done level still held from the just-completed measurement is not spurious.
- Self re-request: a requester pulsing req_start during its own measurement becomes pending and is served after the other pending requesters (round-robin fairness).
- err_clear: clears sticky flags at the next edge. A same-cycle error event wins over the clear.
- grant_id holds its value until the next grant, so the result demux stays valid after req_done.
- Counters: 32-bit down-counters. The only compares are ==0; no wrap is ever reached.

Decomposition:
- Shared package/include holds:
  - State encodings.
  - CLK_FREQ (20000000).
  - ID_W computation.
- Natural sub-module: rr_select — combinational round-robin picker. Inputs: pending vector and last_grant. Outputs: grant index and valid. Reused by later mux schedulers.

Test Plan:
- Single request: req_start[0] pulse at edge 10, ADC model returns done 100 clocks after start → adc_measure_start in the cycle after edge 12, req_done[0] one cycle, req_timeout=0, grant_id=0, then 20 idle clocks.
- Round-robin: req_start[0] and [1] in the same cycle, then continuous re-requests from both → grants alternate 0,1,0,1; neither requester is starved.
- Timeout (TIMEOUT_CLKS=50): no done returned → adc_abort and monitor[1] pulse 50 clocks after start, req_done[i] with req_timeout=1, err_timeout=1 until err_clear. Also done and counter==0 in the same cycle → no timeout.
- Overrun/spurious: req_start[1] twice while pending → err_overrun=2'b10. adc_measure_done pulse in IDLE → err_spurious=1. err_clear → all sticky flags 0.
- Reset mid-WAIT: reset_n=0 for one clock → all outputs 0, pending cleared, a late adc_measure_done afterwards sets err_spurious only.
- HOLDOFF_CLKS=0: back-to-back requests → next adc_measure_start 3 clocks after the previous req_done.
